// File: rtl/golden_nonce_collector.sv
// Collects golden nonces from two mining cores, corrects them by NONCE_OFFSET, queues them and streams them out one at a time.
// Latency: a hit accepted at one edge is on the outputs the following cycle. Backpressure: out_ready stalls the head; hits that find no space are dropped and counted.
module golden_nonce_collector #(
  parameter int          DEPTH        = 4,
  parameter logic [31:0] NONCE_OFFSET = 32'd0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       work_reset,
  input  logic                       found_0,
  input  logic [31:0]                nonce_0,
  input  logic                       found_1,
  input  logic [31:0]                nonce_1,
  output logic                       out_valid,
  output logic [31:0]                out_nonce,
  output logic                       out_core,
  input  logic                       out_ready,
  output logic [7:0]                 overflow_count,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef struct packed {
    logic        core;
    logic [31:0] nonce;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic          pop;
  logic [CW:0]   free;
  logic          wr0, wr1;
  logic [1:0]    n_wr, n_found, n_drop;
  entry_t        e0, e1, head_n;
  logic [AW-1:0] wa1, rd_ptr_n;
  logic [CW-1:0] remain, count_n;
  logic [8:0]    ovf_sum;

  always_comb begin
    pop      = out_valid & out_ready;
    // A pop releases its slot in the same cycle, so it counts towards free space.
    free     = DEPTH_W - {1'b0, count} + {{CW{1'b0}}, pop};
    wr0      = found_0 && (free >= (CW+1)'(1));
    wr1      = found_1 && (found_0 ? (free >= (CW+1)'(2)) : (free >= (CW+1)'(1)));
    n_wr     = {1'b0, wr0} + {1'b0, wr1};
    n_found  = {1'b0, found_0} + {1'b0, found_1};
    n_drop   = n_found - n_wr;
    e0       = '{core: 1'b0, nonce: nonce_0 - NONCE_OFFSET};
    e1       = '{core: 1'b1, nonce: nonce_1 - NONCE_OFFSET};
    wa1      = wr_ptr + AW'(wr0);
    remain   = count - CW'(pop);
    rd_ptr_n = rd_ptr + AW'(pop);
    count_n  = remain + CW'(n_wr);
    // The next head is an older entry if one survives the pop, else the first one written now.
    head_n   = (remain != '0) ? mem[rd_ptr_n] : (wr0 ? e0 : e1);
    ovf_sum  = {1'b0, overflow_count} + 9'(n_drop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      out_valid      <= 1'b0;
      out_nonce      <= '0;
      out_core       <= 1'b0;
      overflow_count <= '0;
    end else if (work_reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (wr0) mem[wr_ptr] <= e0;
      if (wr1) mem[wa1]    <= e1;
      wr_ptr    <= wr_ptr + AW'(n_wr);
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      out_valid <= (count_n != '0);
      if (count_n != '0) begin
        out_nonce <= head_n.nonce;
        out_core  <= head_n.core;
      end
      overflow_count <= (ovf_sum > 9'd255) ? 8'hFF : ovf_sum[7:0];
    end
  end

  assign fifo_count = count;

endmodule

// File: tb/tb_golden_nonce_collector.sv
// Directed and random stimulus for golden_nonce_collector against a queue-based reference model.
module tb_golden_nonce_collector;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] OFF1 = 32'd131;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, work_reset, found_0, found_1, out_ready;
  logic [31:0]   nonce_0, nonce_1;
  logic          v0, v1, c0, c1;
  logic [31:0]   on0, on1;
  logic [7:0]    ov0, ov1;
  logic [CW-1:0] fc0, fc1;

  golden_nonce_collector #(.DEPTH(DEPTH), .NONCE_OFFSET(32'd0)) dut0 (
    .clk(clk), .reset(reset), .work_reset(work_reset),
    .found_0(found_0), .nonce_0(nonce_0), .found_1(found_1), .nonce_1(nonce_1),
    .out_valid(v0), .out_nonce(on0), .out_core(c0), .out_ready(out_ready),
    .overflow_count(ov0), .fifo_count(fc0));

  golden_nonce_collector #(.DEPTH(DEPTH), .NONCE_OFFSET(OFF1)) dut1 (
    .clk(clk), .reset(reset), .work_reset(work_reset),
    .found_0(found_0), .nonce_0(nonce_0), .found_1(found_1), .nonce_1(nonce_1),
    .out_valid(v1), .out_nonce(on1), .out_core(c1), .out_ready(out_ready),
    .overflow_count(ov1), .fifo_count(fc1));

  typedef struct {
    bit        core;
    bit [31:0] raw;
  } ent_t;

  ent_t q[$];
  int   ovf;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_hit(input bit core, input bit [31:0] raw, inout int drops);
    ent_t e;
    e.core = core;
    e.raw  = raw;
    if (q.size() < DEPTH) q.push_back(e);
    else drops++;
  endtask

  task automatic check_all(input string tag);
    bit exp_v;
    exp_v = (q.size() > 0);
    chk({tag, ".valid0"}, 32'(v0),  32'(exp_v));
    chk({tag, ".valid1"}, 32'(v1),  32'(exp_v));
    chk({tag, ".count0"}, 32'(fc0), 32'(q.size()));
    chk({tag, ".count1"}, 32'(fc1), 32'(q.size()));
    chk({tag, ".ovf0"},   32'(ov0), 32'(ovf));
    chk({tag, ".ovf1"},   32'(ov1), 32'(ovf));
    if (exp_v) begin
      chk({tag, ".nonce0"}, on0, q[0].raw);
      chk({tag, ".nonce1"}, on1, q[0].raw - OFF1);
      chk({tag, ".core0"},  32'(c0), 32'(q[0].core));
      chk({tag, ".core1"},  32'(c1), 32'(q[0].core));
    end
  endtask

  // One clock cycle: drive inputs, advance the model over the edge, compare after the edge.
  task automatic step(input string tag, input bit rst, input bit wr,
                      input bit f0, input bit [31:0] n0,
                      input bit f1, input bit [31:0] n1, input bit rdy);
    int drops;
    @(negedge clk);
    reset = rst; work_reset = wr; found_0 = f0; nonce_0 = n0;
    found_1 = f1; nonce_1 = n1; out_ready = rdy;
    @(posedge clk);
    drops = 0;
    if (rst) begin
      q.delete();
      ovf = 0;
    end else if (wr) begin
      q.delete();
    end else begin
      if (q.size() > 0 && rdy) q.delete(0);
      if (f0) push_hit(1'b0, n0, drops);
      if (f1) push_hit(1'b1, n1, drops);
      ovf = (ovf + drops > 255) ? 255 : ovf + drops;
    end
    #1;
    check_all(tag);
    if (rst) begin
      chk({tag, ".rst_nonce0"}, on0, 32'h0);
      chk({tag, ".rst_nonce1"}, on1, 32'h0);
      chk({tag, ".rst_core0"},  32'(c0), 32'h0);
    end
  endtask

  initial begin
    reset = 1'b1; work_reset = 1'b0; found_0 = 1'b0; found_1 = 1'b0;
    nonce_0 = '0; nonce_1 = '0; out_ready = 1'b0;
    q.delete();
    ovf = 0;

    step("reset_a", 1, 0, 0, 0, 0, 0, 0);
    step("reset_b", 1, 0, 0, 0, 0, 0, 0);

    // Single hit appears one cycle later, then one pop drains it.
    step("single", 0, 0, 1, 32'h0e33337a, 0, 0, 0);
    chk("single.nonce_lit", on0, 32'h0e33337a);
    chk("single.count_lit", 32'(fc0), 32'd1);
    step("single_pop", 0, 0, 0, 0, 0, 0, 1);
    chk("single_pop.valid_lit", 32'(v0), 32'd0);

    // Dual hit: core 0 first, then core 1, back to back.
    step("dual", 0, 0, 1, 32'h11111111, 1, 32'h22222222, 1);
    chk("dual.first_lit", on0, 32'h11111111);
    step("dual_pop1", 0, 0, 0, 0, 0, 0, 1);
    chk("dual.second_lit", on0, 32'h22222222);
    chk("dual.second_core_lit", 32'(c0), 32'd1);
    step("dual_pop2", 0, 0, 0, 0, 0, 0, 1);
    chk("dual.ovf_lit", 32'(ov0), 32'd0);

    // Overflow: fill three, dual hit drops core 1, further duals drop both.
    for (int i = 0; i < 3; i++) step("fill", 0, 0, 1, 32'h100 + 32'(i), 0, 0, 0);
    step("ovf_dual1", 0, 0, 1, 32'h200, 1, 32'h201, 0);
    chk("ovf_dual1.count_lit", 32'(fc0), 32'd4);
    chk("ovf_dual1.ovf_lit", 32'(ov0), 32'd1);
    step("ovf_dual2", 0, 0, 1, 32'h300, 1, 32'h301, 0);
    chk("ovf_dual2.ovf_lit", 32'(ov0), 32'd3);
    for (int i = 0; i < 130; i++) step("ovf_sat", 0, 0, 1, $urandom, 1, $urandom, 0);
    chk("ovf_sat.lit", 32'(ov0), 32'd255);

    // Full with simultaneous pop accepts a single core-1 hit.
    step("full_pop", 0, 0, 0, 0, 1, 32'hABCD0001, 1);
    chk("full_pop.count_lit", 32'(fc0), 32'd4);
    chk("full_pop.ovf_lit", 32'(ov0), 32'd255);
    for (int i = 0; i < 4; i++) step("drain", 0, 0, 0, 0, 0, 0, 1);

    // Offset wrap on the second instance.
    step("reset_c", 1, 0, 0, 0, 0, 0, 0);
    step("wrap", 0, 0, 1, 32'h00000005, 0, 0, 0);
    chk("wrap.lit", on1, 32'hFFFFFF82);

    // Flush with concurrent hit, overflow untouched.
    step("pre_flush_a", 0, 0, 1, 32'h1, 1, 32'h2, 0);
    step("pre_flush_b", 0, 0, 1, 32'h3, 1, 32'h4, 0);
    step("pre_flush_c", 0, 0, 1, 32'h5, 0, 0, 0);
    step("flush", 0, 1, 1, 32'h6, 0, 0, 1);
    chk("flush.count_lit", 32'(fc0), 32'd0);
    chk("flush.ovf_lit", 32'(ov0), 32'd2);

    // Reset while a result is stalled.
    step("pre_rst", 0, 0, 1, 32'hDEADBEEF, 0, 0, 0);
    step("pre_rst2", 0, 0, 0, 0, 0, 0, 0);
    step("mid_rst", 1, 0, 0, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 2) == 0), $urandom, ($urandom_range(0, 2) == 0), $urandom,
           $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
